// File: rtl/uart_pkg.sv
// Shared UART definitions for the receiver and the future transmitter.
//   UART_DATA_BITS : payload bits per frame (8N1)
//   rx_state_t     : receiver FSM state encoding
package uart_pkg;

  localparam int UART_DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } rx_state_t;

endpackage

// File: rtl/bit_synchronizer.sv
// Multi-flop synchroniser for a single asynchronous level signal.
// Reusable for rxd, cts and rts crossings.
//   clk   : destination clock
//   reset : synchronous, active-high; loads RESET_VALUE into every stage
//   d     : asynchronous input
//   q     : synchronised output (last stage)
module bit_synchronizer #(
  parameter int   STAGES      = 2,
  parameter logic RESET_VALUE = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync;

  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= {STAGES{RESET_VALUE}};
    end else begin
      sync <= {sync[STAGES-2:0], d};
    end
  end

  assign q = sync[STAGES-1];

endmodule

// File: rtl/uart_receiver.sv
// UART receiver, 8N1, LSB first. Feeds the controller's receive FIFO.
//   clk           : system clock
//   reset         : synchronous, active-high
//   rxd           : asynchronous serial line, idle high
//   data          : last correctly received byte, held between ok strobes
//   ok            : one-cycle strobe, data valid in the same cycle
//   waiting       : high while idle and hunting for a start bit
//   framing_error : one-cycle strobe when the stop bit samples low
//
// Output handshake: ok is a pure strobe with no back-pressure; the consumer
// must capture data in the cycle ok is high. framing_error never coincides
// with ok, and data is left untouched on a framing error.
module uart_receiver
  import uart_pkg::*;
#(
  parameter int CLK_PER_BIT = 868,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       ok,
  output logic       waiting,
  output logic       framing_error
);

  localparam int CNT_W = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [2:0]       LAST_IDX  = 3'(UART_DATA_BITS - 1);

  logic rx_s;

  bit_synchronizer #(
    .STAGES      (SYNC_STAGES),
    .RESET_VALUE (1'b1)
  ) u_rx_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rxd),
    .q     (rx_s)
  );

  rx_state_t                 state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [2:0]                idx_q, idx_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [7:0]                data_d;
  logic                      ok_d, fe_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      idx_q         <= '0;
      shift_q       <= '0;
      data          <= 8'h00;
      ok            <= 1'b0;
      framing_error <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      idx_q         <= idx_d;
      shift_q       <= shift_d;
      data          <= data_d;
      ok            <= ok_d;
      framing_error <= fe_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data;
    ok_d    = 1'b0;
    fe_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (!rx_s) begin
          cnt_d   = '0;
          state_d = START;
        end
      end

      // Wait half a bit so every later sample lands mid-bit; a line that is
      // high again by then was only a glitch.
      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (!rx_s) begin
            idx_d   = '0;
            state_d = DATA;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == LAST_IDX) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Leaving at the middle of the stop bit gives half a bit of slack to
      // catch a start edge that immediately follows.
      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            ok_d    = 1'b1;
            state_d = IDLE;
          end else begin
            fe_d    = 1'b1;
            state_d = BREAK;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      // Line held low after a bad stop bit: wait for it to return high so a
      // long break yields a single framing error and no phantom bytes.
      BREAK: begin
        if (rx_s) begin
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign waiting = (state_q == IDLE);

endmodule
